// File: rtl/rs_encoder.sv
// rs_encoder -- systematic RS(204,188, t=8) encoder over GF(2^8), p(x)=11Dh, alpha=02h.
// Generator g(x) = prod (x + alpha^i), i=0..15; RS(255,239) shortened by 51 bytes.
// Each 188-byte packet passes through unchanged with one cycle of latency.
// Sixteen parity bytes follow it, highest degree first.
//
// Handshake: a byte moves when In_Valid & In_Ready on a rising Clk edge.
// In_Ready is high only in the DATA state. The output side has no backpressure:
// Out_Valid marks a codeword byte that the consumer must take in that cycle.
//
// Optional build macro RS_ENC_ERR_INJECT_EN adds Inject_Mask[7:0].
// That mask is XORed onto every valid output byte, both data and parity.
// The LFSR always sees the clean byte.
// Dbg_State exposes the FSM state (0 = DATA, 1 = PARITY).
module rs_encoder (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       In_Valid,
    input  logic       In_Sop,
    input  logic [7:0] In_Data,
`ifdef RS_ENC_ERR_INJECT_EN
    input  logic [7:0] Inject_Mask,
`endif
    output logic       In_Ready,
    output logic       Out_Valid,
    output logic       Out_Sop,
    output logic       Out_Eop,
    output logic [7:0] Out_Data,
    output logic       Sync_Err,
    output logic       Dbg_State
);

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    // GF(2^8) multiply reduced by x^8+x^4+x^3+x^2+1; with one constant operand it folds to XORs
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Expands prod (x + alpha^i) at elaboration; returns g_0..g_15 (g_16 = 1 is implicit)
    function automatic logic [15:0][7:0] gen_poly();
        logic [7:0]       gd [0:16];
        logic [7:0]       root;
        logic [15:0][7:0] res;
        for (int j = 0; j <= 16; j++) gd[j] = 8'h00;
        gd[0] = 8'h01;
        root  = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j >= 1; j--) gd[j] = gd[j-1] ^ gf_mul(gd[j], root);
            gd[0] = gf_mul(gd[0], root);
            root  = gf_mul(root, 8'h02);
        end
        for (int j = 0; j < 16; j++) res[j] = gd[j];
        return res;
    endfunction

    localparam logic [15:0][7:0] G_COEF   = gen_poly();
    localparam logic [7:0]       LAST_IDX = 8'd187;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_cnt;
    logic [3:0] r_pcnt;
    logic [7:0] r_lfsr [16];

    logic       r_out_valid;
    logic       r_out_sop;
    logic       r_out_eop;
    logic [7:0] r_out_data;
    logic       r_sync_err;

    logic       w_accept;
    logic       w_restart;
    logic       w_stray;
    logic       w_normal;
    logic [7:0] w_mask;
    logic [7:0] w_fb;
    logic [7:0] w_lfsr_d [16];
    logic [7:0] w_cnt_d;
    logic [3:0] w_pcnt_d;
    logic       w_out_valid_d;
    logic       w_out_sop_d;
    logic       w_out_eop_d;
    logic [7:0] w_out_byte_d;
    logic       w_sync_err_d;

    assign In_Ready  = (r_state == ST_DATA);
    assign Dbg_State = r_state;
    assign Out_Valid = r_out_valid;
    assign Out_Sop   = r_out_sop;
    assign Out_Eop   = r_out_eop;
    assign Out_Data  = r_out_data;
    assign Sync_Err  = r_sync_err;

`ifdef RS_ENC_ERR_INJECT_EN
    assign w_mask = Inject_Mask;
`else
    assign w_mask = 8'h00;
`endif

    // Classify an accepted byte: packet start, out-of-sync stray, or in-packet continuation
    assign w_accept  = In_Valid & In_Ready;
    assign w_restart = w_accept & In_Sop;
    assign w_stray   = w_accept & ~In_Sop & (r_cnt == 8'd0);
    assign w_normal  = w_accept & ~In_Sop & (r_cnt != 8'd0);

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_DATA;
        else       r_state <= w_next_state;
    end

    // Next state: leave DATA on byte 187; return after the 16th parity byte
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_DATA:   if (w_normal && (r_cnt == LAST_IDX)) w_next_state = ST_PARITY;
            ST_PARITY: if (r_pcnt == 4'd15)                 w_next_state = ST_DATA;
            default:   w_next_state = ST_DATA;
        endcase
    end

    // Output and datapath: LFSR update, counters and the next registered output byte
    always_comb begin
        w_fb          = 8'h00;
        w_cnt_d       = r_cnt;
        w_pcnt_d      = r_pcnt;
        w_out_valid_d = 1'b0;
        w_out_sop_d   = 1'b0;
        w_out_eop_d   = 1'b0;
        w_out_byte_d  = 8'h00;
        w_sync_err_d  = 1'b0;
        for (int i = 0; i < 16; i++) w_lfsr_d[i] = r_lfsr[i];
        case (r_state)
            ST_DATA: begin
                if (w_restart) begin
                    // New packet: feedback as if the register were all zero
                    w_fb = In_Data;
                    for (int i = 0; i < 16; i++) w_lfsr_d[i] = gf_mul(G_COEF[i], w_fb);
                    w_cnt_d       = 8'd1;
                    w_out_valid_d = 1'b1;
                    w_out_sop_d   = 1'b1;
                    w_out_byte_d  = In_Data;
                    w_sync_err_d  = (r_cnt != 8'd0);
                end else if (w_stray) begin
                    w_sync_err_d = 1'b1;
                end else if (w_normal) begin
                    w_fb        = In_Data ^ r_lfsr[15];
                    w_lfsr_d[0] = gf_mul(G_COEF[0], w_fb);
                    for (int i = 1; i < 16; i++) w_lfsr_d[i] = r_lfsr[i-1] ^ gf_mul(G_COEF[i], w_fb);
                    w_out_valid_d = 1'b1;
                    w_out_byte_d  = In_Data;
                    if (r_cnt == LAST_IDX) w_pcnt_d = 4'd0;
                    else                   w_cnt_d  = r_cnt + 8'd1;
                end
            end
            ST_PARITY: begin
                w_out_valid_d = 1'b1;
                w_out_byte_d  = r_lfsr[15];
                w_lfsr_d[0]   = 8'h00;
                for (int i = 1; i < 16; i++) w_lfsr_d[i] = r_lfsr[i-1];
                w_pcnt_d = r_pcnt + 4'd1;
                if (r_pcnt == 4'd15) begin
                    w_out_eop_d = 1'b1;
                    w_cnt_d     = 8'd0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset drops any codeword in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt       <= 8'd0;
            r_pcnt      <= 4'd0;
            for (int i = 0; i < 16; i++) r_lfsr[i] <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_data  <= 8'h00;
            r_sync_err  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_d;
            r_pcnt      <= w_pcnt_d;
            for (int i = 0; i < 16; i++) r_lfsr[i] <= w_lfsr_d[i];
            r_out_valid <= w_out_valid_d;
            r_out_sop   <= w_out_sop_d;
            r_out_eop   <= w_out_eop_d;
            r_out_data  <= w_out_valid_d ? (w_out_byte_d ^ w_mask) : 8'h00;
            r_sync_err  <= w_sync_err_d;
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// Testbench for rs_encoder: directed packets checked against a long-division
// reference encoder and against codeword syndromes.
module tb_rs_encoder;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       In_Valid = 1'b0;
    logic       In_Sop = 1'b0;
    logic [7:0] In_Data = 8'h00;
    logic [7:0] Inject_Mask = 8'h00;
    logic       In_Ready, Out_Valid, Out_Sop, Out_Eop, Sync_Err, Dbg_State;
    logic [7:0] Out_Data;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int sync_cnt = 0;
    int ready_low_cnt = 0;
    bit inj_on = 1'b0;

    logic [7:0] cap_q[$];
    bit         cap_sop_q[$];
    bit         cap_eop_q[$];
    int         cap_cyc_q[$];
    logic [7:0] exp_q[$];

    logic [7:0] gd [0:16];
    logic [7:0] tx_msg [0:187];
    logic [7:0] msg_a [0:187];
    logic [7:0] msg_b [0:187];
    logic [7:0] par_a [0:15];
    logic [7:0] par_b [0:15];
    logic [7:0] got_d [0:203];
    bit         got_sop [0:203];
    bit         got_eop [0:203];
    int         got_cyc [0:203];

    rs_encoder dut (
        .Clk(Clk),
        .Reset(Reset),
        .In_Valid(In_Valid),
        .In_Sop(In_Sop),
        .In_Data(In_Data),
`ifdef RS_ENC_ERR_INJECT_EN
        .Inject_Mask(Inject_Mask),
`endif
        .In_Ready(In_Ready),
        .Out_Valid(Out_Valid),
        .Out_Sop(Out_Sop),
        .Out_Eop(Out_Eop),
        .Out_Data(Out_Data),
        .Sync_Err(Sync_Err),
        .Dbg_State(Dbg_State)
    );

    // clock
    always #5 Clk = ~Clk;

    // output monitor, sampled on the falling edge
    always @(negedge Clk) begin
        cyc++;
        if (!Reset) begin
            if (Out_Valid) begin
                cap_q.push_back(Out_Data);
                cap_sop_q.push_back(Out_Sop);
                cap_eop_q.push_back(Out_Eop);
                cap_cyc_q.push_back(cyc);
            end
            if (Sync_Err)  sync_cnt++;
            if (!In_Ready) ready_low_cnt++;
        end
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // syndrome S_k of the collected codeword got_d, evaluated at alpha^k
    function automatic logic [7:0] syndrome(input int k);
        logic [7:0] a = 8'h01;
        logic [7:0] s = 8'h00;
        for (int i = 0; i < k; i++) a = gf_mul(a, 8'h02);
        for (int i = 0; i < 204; i++) s = gf_mul(s, a) ^ got_d[i];
        return s;
    endfunction

    task automatic build_gen();
        logic [7:0] root = 8'h01;
        for (int j = 0; j <= 16; j++) gd[j] = 8'h00;
        gd[0] = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j >= 1; j--) gd[j] = gd[j-1] ^ gf_mul(gd[j], root);
            gd[0] = gf_mul(gd[0], root);
            root = gf_mul(root, 8'h02);
        end
    endtask

    // reference encoder: long division of m(x)*x^16 by g(x); pushes the codeword onto exp_q
    task automatic expect_cw();
        logic [7:0] wk [0:203];
        logic [7:0] c;
        for (int i = 0; i < 204; i++) wk[i] = (i < 188) ? tx_msg[i] : 8'h00;
        for (int i = 0; i < 188; i++) begin
            c = wk[i];
            for (int j = 0; j <= 16; j++) wk[i+j] ^= gf_mul(c, gd[16-j]);
        end
        for (int i = 0; i < 188; i++) exp_q.push_back(tx_msg[i]);
        for (int i = 188; i < 204; i++) exp_q.push_back(wk[i]);
    endtask

    task automatic drive_byte(input logic [7:0] data, input bit sop, input logic [7:0] mask);
        int w = 0;
        @(negedge Clk);
        while (!In_Ready && w < 200) begin
            @(negedge Clk);
            w++;
        end
        n_vec++;
        if (In_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_wait: In_Ready=%b after %0d cycles, need 1", In_Ready, w);
        end
        In_Valid = 1'b1;
        In_Sop = sop;
        In_Data = data;
        Inject_Mask = mask;
        @(posedge Clk);
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        In_Valid = 1'b0;
        In_Sop = 1'b0;
        Inject_Mask = 8'h00;
        repeat (n - 1) @(negedge Clk);
    endtask

    task automatic send_bytes(input int first, input int last, input int gap_pct);
        logic [7:0] m;
        for (int i = first; i <= last; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            m = (inj_on && (i == 10 || i == 50)) ? 8'h5A : 8'h00;
            drive_byte(tx_msg[i], (i == first), m);
        end
    endtask

    // pops n captured bytes into got_*; ok=0 if they did not all appear in time
    task automatic collect(input int n, output bit ok);
        int w = 0;
        while (cap_q.size() < n && w < 3000) begin
            @(posedge Clk);
            w++;
        end
        ok = (cap_q.size() >= n);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                got_d[i] = cap_q.pop_front();
                got_sop[i] = cap_sop_q.pop_front();
                got_eop[i] = cap_eop_q.pop_front();
                got_cyc[i] = cap_cyc_q.pop_front();
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        n_vec++;
        if ({In_Ready, Out_Valid, Out_Sop, Out_Eop, Sync_Err, Dbg_State} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: {rdy,vld,sop,eop,err,st}=%b need 100000",
                     {In_Ready, Out_Valid, Out_Sop, Out_Eop, Sync_Err, Dbg_State});
        end
        n_vec++;
        if (Out_Data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: Out_Data=%h need 00", Out_Data);
        end
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        n_vec++;
        if ({In_Ready, Out_Valid, Out_Sop, Out_Eop, Sync_Err} !== 5'b10000) begin
            n_err++;
            $display("FAIL idle_ctrl: {rdy,vld,sop,eop,err}=%b need 10000",
                     {In_Ready, Out_Valid, Out_Sop, Out_Eop, Sync_Err});
        end
        n_vec++;
        if (cap_q.size() !== 0) begin
            n_err++;
            $display("FAIL idle_output: %0d bytes seen, need 0", cap_q.size());
        end
    endtask

    task automatic test_zero_packet();
        bit ok;
        int nsop = 0;
        int neop = 0;
        logic [7:0] e;
        for (int i = 0; i < 188; i++) tx_msg[i] = 8'h00;
        expect_cw();
        ready_low_cnt = 0;
        send_bytes(0, 187, 0);
        idle(1);
        collect(204, ok);
        repeat (4) @(negedge Clk);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL zero_collect: %0d bytes, need 204", cap_q.size());
        end
        for (int i = 0; i < 204; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_d[i] !== e) begin
                n_err++;
                $display("FAIL zero_byte[%0d]: got %h need %h", i, got_d[i], e);
            end
            nsop += got_sop[i];
            neop += got_eop[i];
        end
        n_vec++;
        if (got_sop[0] !== 1'b1 || got_eop[203] !== 1'b1 || nsop !== 1 || neop !== 1) begin
            n_err++;
            $display("FAIL zero_flags: sop0=%b eop203=%b nsop=%0d neop=%0d need 1 1 1 1",
                     got_sop[0], got_eop[203], nsop, neop);
        end
        n_vec++;
        if (ready_low_cnt !== 16) begin
            n_err++;
            $display("FAIL zero_ready_window: low %0d cycles, need 16", ready_low_cnt);
        end
    endtask

    task automatic test_impulse();
        bit ok;
        logic [7:0] e;
        for (int i = 0; i < 188; i++) tx_msg[i] = 8'h00;
        tx_msg[187] = 8'h01;
        expect_cw();
        send_bytes(0, 187, 0);
        idle(1);
        collect(204, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL impulse_collect: %0d bytes, need 204", cap_q.size());
        end
        for (int i = 0; i < 204; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_d[i] !== e) begin
                n_err++;
                $display("FAIL impulse_byte[%0d]: got %h need %h", i, got_d[i], e);
            end
        end
        for (int k = 0; k < 16; k++) begin
            n_vec++;
            if (got_d[188+k] !== gd[15-k]) begin
                n_err++;
                $display("FAIL impulse_gcoef[%0d]: got %h need g_%0d=%h", k, got_d[188+k], 15-k, gd[15-k]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            n_vec++;
            if (syndrome(k) !== 8'h00) begin
                n_err++;
                $display("FAIL impulse_syn[%0d]: got %h need 00", k, syndrome(k));
            end
        end
    endtask

    task automatic test_linearity_back_to_back();
        bit ok;
        logic [7:0] e;
        int last_c;
        sync_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            // packets: A (gaps), B (gaps), A^B and B again (In_Valid held high)
            for (int i = 0; i < 188; i++) begin
                if (p == 0) begin msg_a[i] = 8'($urandom_range(0, 255)); tx_msg[i] = msg_a[i]; end
                if (p == 1) begin msg_b[i] = 8'($urandom_range(0, 255)); tx_msg[i] = msg_b[i]; end
                if (p == 2) tx_msg[i] = msg_a[i] ^ msg_b[i];
                if (p == 3) tx_msg[i] = msg_b[i];
            end
            expect_cw();
            send_bytes(0, 187, (p < 2) ? 25 : 0);
            if (p < 2 || p == 3) idle(1);
            if (p < 2) begin
                collect(204, ok);
                n_vec++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL lin_collect[%0d]: %0d bytes, need 204", p, cap_q.size());
                end
                for (int i = 0; i < 204; i++) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (got_d[i] !== e) begin
                        n_err++;
                        $display("FAIL lin_byte[%0d][%0d]: got %h need %h", p, i, got_d[i], e);
                    end
                end
                for (int k = 0; k < 16; k++) begin
                    if (p == 0) par_a[k] = got_d[188+k];
                    else        par_b[k] = got_d[188+k];
                end
            end
        end
        for (int p = 2; p < 4; p++) begin
            collect(204, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL b2b_collect[%0d]: %0d bytes, need 204", p, cap_q.size());
            end
            for (int i = 0; i < 204; i++) begin
                e = exp_q.pop_front();
                n_vec++;
                if (got_d[i] !== e) begin
                    n_err++;
                    $display("FAIL b2b_byte[%0d][%0d]: got %h need %h", p, i, got_d[i], e);
                end
            end
            for (int k = 0; k < 16; k++) begin
                n_vec++;
                if (syndrome(k) !== 8'h00) begin
                    n_err++;
                    $display("FAIL b2b_syn[%0d][%0d]: got %h need 00", p, k, syndrome(k));
                end
            end
            n_vec++;
            if (got_cyc[203] - got_cyc[0] !== 203) begin
                n_err++;
                $display("FAIL b2b_span[%0d]: codeword spans %0d cycles, need 203", p, got_cyc[203] - got_cyc[0]);
            end
            if (p == 2) begin
                for (int k = 0; k < 16; k++) begin
                    n_vec++;
                    if (got_d[188+k] !== (par_a[k] ^ par_b[k])) begin
                        n_err++;
                        $display("FAIL linearity[%0d]: got %h need %h", k, got_d[188+k], par_a[k] ^ par_b[k]);
                    end
                end
                last_c = got_cyc[203];
            end else begin
                n_vec++;
                if (got_cyc[0] !== last_c + 1) begin
                    n_err++;
                    $display("FAIL b2b_gap: next codeword at cycle %0d, need %0d", got_cyc[0], last_c + 1);
                end
            end
        end
        n_vec++;
        if (sync_cnt !== 0) begin
            n_err++;
            $display("FAIL lin_sync_err: %0d pulses, need 0", sync_cnt);
        end
    endtask

    task automatic test_framing();
        bit ok;
        int neop = 0;
        logic [7:0] e;
        sync_cnt = 0;
        for (int i = 0; i < 188; i++) tx_msg[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 100; i++) exp_q.push_back(tx_msg[i]);
        send_bytes(0, 99, 0);
        for (int i = 0; i < 188; i++) tx_msg[i] = 8'($urandom_range(0, 255));
        expect_cw();
        send_bytes(0, 187, 0);
        idle(1);
        collect(100, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL frame_partial_collect: %0d bytes, need 100", cap_q.size());
        end
        for (int i = 0; i < 100; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_d[i] !== e) begin
                n_err++;
                $display("FAIL frame_partial[%0d]: got %h need %h", i, got_d[i], e);
            end
            neop += got_eop[i];
        end
        n_vec++;
        if (neop !== 0) begin
            n_err++;
            $display("FAIL frame_no_parity: %0d eop in abandoned packet, need 0", neop);
        end
        collect(204, ok);
        n_vec++;
        if (!ok || got_sop[0] !== 1'b1 || got_eop[203] !== 1'b1) begin
            n_err++;
            $display("FAIL frame_second_flags: ok=%b sop=%b eop=%b need 1 1 1", ok, got_sop[0], got_eop[203]);
        end
        for (int i = 0; i < 204; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_d[i] !== e) begin
                n_err++;
                $display("FAIL frame_second[%0d]: got %h need %h", i, got_d[i], e);
            end
        end
        repeat (2) @(negedge Clk);
        n_vec++;
        if (sync_cnt !== 1) begin
            n_err++;
            $display("FAIL frame_sync_err: %0d pulse cycles, need 1", sync_cnt);
        end
        sync_cnt = 0;
        drive_byte(8'h33, 1'b0, 8'h00);
        idle(5);
        n_vec++;
        if (sync_cnt !== 1 || cap_q.size() !== 0) begin
            n_err++;
            $display("FAIL stray_byte: sync pulses %0d, out bytes %0d, need 1 and 0", sync_cnt, cap_q.size());
        end
    endtask

    task automatic test_reset_mid_parity();
        bit ok;
        int w = 0;
        int neop = 0;
        int nbytes;
        logic [7:0] e;
        for (int i = 0; i < 188; i++) tx_msg[i] = 8'($urandom_range(0, 255));
        send_bytes(0, 187, 0);
        idle(1);
        while (cap_q.size() < 193 && w < 1000) begin
            @(posedge Clk);
            #1;
            w++;
        end
        // parity byte 5 is on the output now; reset lands mid-cycle
        Reset = 1'b1;
        #1;
        n_vec++;
        if ({Out_Valid, Out_Eop, Out_Sop, Sync_Err, In_Ready} !== 5'b00001 || Out_Data !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: {vld,eop,sop,err,rdy}=%b data=%h need 00001 00",
                     {Out_Valid, Out_Eop, Out_Sop, Sync_Err, In_Ready}, Out_Data);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        nbytes = cap_q.size();
        while (cap_q.size() > 0) begin
            void'(cap_q.pop_front());
            void'(cap_sop_q.pop_front());
            neop += cap_eop_q.pop_front();
            void'(cap_cyc_q.pop_front());
        end
        n_vec++;
        if (nbytes !== 193 || neop !== 0) begin
            n_err++;
            $display("FAIL reset_truncate: %0d bytes %0d eop, need 193 and 0", nbytes, neop);
        end
        for (int i = 0; i < 188; i++) tx_msg[i] = 8'($urandom_range(0, 255));
        expect_cw();
        send_bytes(0, 187, 10);
        idle(1);
        collect(204, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL post_reset_collect: %0d bytes, need 204", cap_q.size());
        end
        for (int i = 0; i < 204; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_d[i] !== e) begin
                n_err++;
                $display("FAIL post_reset[%0d]: got %h need %h", i, got_d[i], e);
            end
        end
    endtask

`ifdef RS_ENC_ERR_INJECT_EN
    task automatic test_inject();
        bit ok;
        logic [7:0] e;
        for (int i = 0; i < 188; i++) tx_msg[i] = 8'($urandom_range(0, 255));
        expect_cw();
        inj_on = 1'b1;
        send_bytes(0, 187, 0);
        inj_on = 1'b0;
        idle(1);
        collect(204, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL inject_collect: %0d bytes, need 204", cap_q.size());
        end
        for (int i = 0; i < 204; i++) begin
            e = exp_q.pop_front() ^ ((i == 10 || i == 50) ? 8'h5A : 8'h00);
            n_vec++;
            if (got_d[i] !== e) begin
                n_err++;
                $display("FAIL inject_byte[%0d]: got %h need %h", i, got_d[i], e);
            end
        end
        n_vec++;
        if (syndrome(1) === 8'h00) begin
            n_err++;
            $display("FAIL inject_syn1: got 00 need nonzero");
        end
    endtask
`endif

    initial begin
        build_gen();
        test_reset();
        test_zero_packet();
        test_impulse();
        test_linearity_back_to_back();
        test_framing();
        test_reset_mid_parity();
`ifdef RS_ENC_ERR_INJECT_EN
        test_inject();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
